// File: rtl/aha_reset_pkg.sv
// aha_reset_pkg: shared state encoding, width helpers and parameter legality for the reset sequencer
package aha_reset_pkg;
    typedef enum logic [1:0] {HOLD, RELEASE, RUN, QUIESCE} seq_state_e;

    function automatic int timer_width(int assert_cycles, int stage_delay, int quiesce_timeout);
        int m;
        m = assert_cycles > stage_delay ? assert_cycles : stage_delay;
        m = m > quiesce_timeout ? m : quiesce_timeout;
        return $clog2(m + 1);
    endfunction

    function automatic int index_width(int num_stages);
        return num_stages > 1 ? $clog2(num_stages) : 1;
    endfunction

    function automatic bit params_ok(int num_stages, int assert_cycles, int stage_delay, int quiesce_timeout);
        return num_stages >= 1 && num_stages <= 8 && assert_cycles >= 1 && stage_delay >= 1 && quiesce_timeout >= 1;
    endfunction
endpackage

// File: rtl/aha_reset_sequencer_if.sv
// aha_reset_sequencer_if: warm-reset handshake and staged reset outputs of the sequencer
interface aha_reset_sequencer_if #(parameter int NUM_STAGES = 4);
    logic                  SW_RESET_REQ;
    logic                  QUIESCE_ACK;
    logic                  QUIESCE_REQ;
    logic [NUM_STAGES-1:0] STAGE_RESETn;
    logic                  RESET_DONE;
    logic                  TIMEOUT_FLAG;
    modport master (
        input  SW_RESET_REQ, QUIESCE_ACK,
        output QUIESCE_REQ, STAGE_RESETn, RESET_DONE, TIMEOUT_FLAG
    );
    modport slave (
        output SW_RESET_REQ, QUIESCE_ACK,
        input  QUIESCE_REQ, STAGE_RESETn, RESET_DONE, TIMEOUT_FLAG
    );
endinterface

// File: rtl/aha_reset_seq_timer.sv
// aha_reset_seq_timer: saturating edge counter, cleared on state change, flags the last edge of a wait
module aha_reset_seq_timer #(
    parameter int W = 7
) (
    input  logic         CLK,
    input  logic         RESETn,
    input  logic         clear,
    input  logic [W-1:0] last,
    output logic         expired
);
    logic [W-1:0] count;

    always_ff @(posedge CLK or negedge RESETn)
        if (!RESETn) count <= '0;
        else count <= clear ? '0 : (&count ? count : count + 1'b1);

    assign expired = count == last;
endmodule

// File: rtl/aha_reset_sequencer.sv
// aha_reset_sequencer: holds per-stage resets, releases them in index order with a fixed gap,
// and performs software warm reset through a quiesce handshake with timeout.
module aha_reset_sequencer
    import aha_reset_pkg::*;
#(
    parameter int NUM_STAGES      = 4,
    parameter int ASSERT_CYCLES   = 8,
    parameter int STAGE_DELAY     = 16,
    parameter int QUIESCE_TIMEOUT = 64
) (
    input logic                   CLK,
    input logic                   RESETn,
    aha_reset_sequencer_if.master bus
);
    localparam int TW = timer_width(ASSERT_CYCLES, STAGE_DELAY, QUIESCE_TIMEOUT);
    localparam int IW = index_width(NUM_STAGES);

    if (!params_ok(NUM_STAGES, ASSERT_CYCLES, STAGE_DELAY, QUIESCE_TIMEOUT)) begin : g_illegal
        $error("aha_reset_sequencer: illegal parameter set");
    end

    seq_state_e            state, state_n;
    logic [NUM_STAGES-1:0] stage, stage_n;
    logic [IW-1:0]         idx, idx_n;
    logic [TW-1:0]         last;
    logic                  qreq, qreq_n, done, tflag, tflag_n, clear, expired;

    // the timer waits for the count belonging to the state it is currently in
    assign last = state == HOLD    ? TW'(ASSERT_CYCLES - 1) :
                  state == RELEASE ? TW'(STAGE_DELAY - 1)   : TW'(QUIESCE_TIMEOUT - 1);

    aha_reset_seq_timer #(.W(TW)) u_timer (
        .CLK     (CLK),
        .RESETn  (RESETn),
        .clear   (clear),
        .last    (last),
        .expired (expired)
    );

    always_comb begin
        state_n = state;
        stage_n = stage;
        idx_n   = idx;
        qreq_n  = qreq;
        tflag_n = tflag;
        clear   = 1'b0;
        case (state)
            HOLD: begin
                clear = bus.SW_RESET_REQ || expired;
                if (!bus.SW_RESET_REQ && expired) begin
                    stage_n = NUM_STAGES'(1);
                    state_n = NUM_STAGES == 1 ? RUN : RELEASE;
                end
            end
            RELEASE: begin
                clear = 1'b1;
                if (bus.SW_RESET_REQ) begin
                    state_n = HOLD;
                    stage_n = '0;
                    idx_n   = '0;
                end else if (idx == IW'(NUM_STAGES - 1)) begin
                    state_n = RUN;
                end else if (expired) begin
                    stage_n = (stage << 1) | NUM_STAGES'(1);
                    idx_n   = idx + 1'b1;
                end else begin
                    clear = 1'b0;
                end
            end
            RUN: begin
                if (bus.SW_RESET_REQ) begin
                    state_n = QUIESCE;
                    qreq_n  = 1'b1;
                    clear   = 1'b1;
                end
            end
            QUIESCE: begin
                // an ACK on the timeout edge counts as a clean drain
                if (bus.QUIESCE_ACK || expired) begin
                    state_n = HOLD;
                    stage_n = '0;
                    idx_n   = '0;
                    qreq_n  = 1'b0;
                    clear   = 1'b1;
                    tflag_n = tflag || !bus.QUIESCE_ACK;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn)
        if (!RESETn) begin
            state <= HOLD;
            stage <= '0;
            idx   <= '0;
            qreq  <= 1'b0;
            done  <= 1'b0;
            tflag <= 1'b0;
        end else begin
            state <= state_n;
            stage <= stage_n;
            idx   <= idx_n;
            qreq  <= qreq_n;
            done  <= state_n == RUN;
            tflag <= tflag_n;
        end

    assign bus.STAGE_RESETn = stage;
    assign bus.QUIESCE_REQ  = qreq;
    assign bus.RESET_DONE   = done;
    assign bus.TIMEOUT_FLAG = tflag;
endmodule

// File: tb/tb_aha_reset_sequencer.sv
// tb_aha_reset_sequencer: timing-formula model compared every cycle, plus hand-computed checkpoints
module tb_aha_reset_sequencer;
    localparam int N = 4;
    localparam int A = 8;
    localparam int D = 16;
    localparam int Q = 64;
    localparam int DONE_AT = N == 1 ? A : A + (N - 1) * D + 1;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   edge_n = 0;

    aha_reset_sequencer_if #(.NUM_STAGES(N)) bus ();

    aha_reset_sequencer #(
        .NUM_STAGES      (N),
        .ASSERT_CYCLES   (A),
        .STAGE_DELAY     (D),
        .QUIESCE_TIMEOUT (Q)
    ) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RESETn)
        if (!RESETn) edge_n <= 0;
        else edge_n <= edge_n + 1;

    // model: edges since the sequence restarted, or edges spent waiting for quiesce
    logic         m_quiesce = 1'b0;
    int           m_since = 0;
    int           m_q = 0;
    logic         m_tf = 1'b0;
    logic [N-1:0] exp_stage;
    logic         exp_done, exp_qreq;

    function automatic int n_rel(int s);
        int r;
        r = s < A ? 0 : (s - A) / D + 1;
        return r > N ? N : r;
    endfunction

    assign exp_done  = !m_quiesce && m_since >= DONE_AT;
    assign exp_qreq  = m_quiesce;
    assign exp_stage = m_quiesce ? {N{1'b1}} : N'((1 << n_rel(m_since)) - 1);

    always @(posedge CLK or negedge RESETn)
        if (!RESETn) begin
            m_quiesce <= 1'b0;
            m_since   <= 0;
            m_q       <= 0;
            m_tf      <= 1'b0;
        end else if (!m_quiesce) begin
            if (bus.SW_RESET_REQ && exp_done) begin
                m_quiesce <= 1'b1;
                m_q       <= 0;
            end else begin
                m_since <= bus.SW_RESET_REQ ? 0 : m_since + 1;
            end
        end else if (bus.QUIESCE_ACK || m_q + 1 == Q) begin
            m_quiesce <= 1'b0;
            m_since   <= 0;
            m_tf      <= m_tf || !bus.QUIESCE_ACK;
        end else begin
            m_q <= m_q + 1;
        end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        check("model.stage", 32'(bus.STAGE_RESETn), 32'(exp_stage));
        check("model.qreq", 32'(bus.QUIESCE_REQ), 32'(exp_qreq));
        check("model.done", 32'(bus.RESET_DONE), 32'(exp_done));
        check("model.tflag", 32'(bus.TIMEOUT_FLAG), 32'(m_tf));
    end

    task automatic lit(string tag, logic [N-1:0] st, logic q, logic d, logic t);
        check({tag, ".stage"}, 32'(bus.STAGE_RESETn), 32'(st));
        check({tag, ".qreq"}, 32'(bus.QUIESCE_REQ), 32'(q));
        check({tag, ".done"}, 32'(bus.RESET_DONE), 32'(d));
        check({tag, ".tflag"}, 32'(bus.TIMEOUT_FLAG), 32'(t));
    endtask

    task automatic goto(int e);
        while (edge_n < e) @(negedge CLK);
    endtask

    task automatic pulse_sw(int e);
        goto(e - 1);
        bus.SW_RESET_REQ = 1'b1;
        goto(e);
        bus.SW_RESET_REQ = 1'b0;
    endtask

    task automatic pulse_ack(int e);
        goto(e - 1);
        bus.QUIESCE_ACK = 1'b1;
        goto(e);
        bus.QUIESCE_ACK = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, edge %0d", edge_n);
        $fatal(1);
    end

    initial begin
        bus.SW_RESET_REQ = 1'b0;
        bus.QUIESCE_ACK  = 1'b0;
        repeat (3) @(negedge CLK);
        lit("por_reset", 4'b0000, 0, 0, 0);
        RESETn = 1'b1;
        // power-on release
        goto(7);  lit("por_e7", 4'b0000, 0, 0, 0);
        goto(8);  lit("por_e8", 4'b0001, 0, 0, 0);
        goto(24); lit("por_e24", 4'b0011, 0, 0, 0);
        goto(40); lit("por_e40", 4'b0111, 0, 0, 0);
        goto(56); lit("por_e56", 4'b1111, 0, 0, 0);
        goto(57); lit("por_e57", 4'b1111, 0, 1, 0);
        // warm reset acknowledged after 5 edges
        pulse_sw(60); lit("warm_e60", 4'b1111, 1, 0, 0);
        goto(64);     lit("warm_e64", 4'b1111, 1, 0, 0);
        pulse_ack(65); lit("warm_ack", 4'b0000, 0, 0, 0);
        goto(72);     lit("warm_e72", 4'b0000, 0, 0, 0);
        goto(73);     lit("warm_e73", 4'b0001, 0, 0, 0);
        goto(122);    lit("warm_done", 4'b1111, 0, 1, 0);
        // quiesce timeout, flag sticky through the re-sequence
        pulse_sw(130);
        goto(193); lit("to_e193", 4'b1111, 1, 0, 0);
        goto(194); lit("to_e194", 4'b0000, 0, 0, 1);
        goto(202); lit("to_e202", 4'b0001, 0, 0, 1);
        goto(251); lit("to_done", 4'b1111, 0, 1, 1);
        // asynchronous reset while quiescing
        pulse_sw(255);
        goto(260);
        #2 RESETn = 1'b0;
        #1 lit("async", 4'b0000, 0, 0, 0);
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        goto(8);  lit("re_e8", 4'b0001, 0, 0, 0);
        goto(57); lit("re_e57", 4'b1111, 0, 1, 0);
        // ACK arrives on the timeout edge
        pulse_sw(60);
        pulse_ack(124); lit("tie_e124", 4'b0000, 0, 0, 0);
        goto(132);      lit("tie_e132", 4'b0001, 0, 0, 0);
        goto(148);      lit("rel_e148", 4'b0011, 0, 0, 0);
        // request during release restarts the hold without quiesce
        pulse_sw(150); lit("rel_e150", 4'b0000, 0, 0, 0);
        goto(157);     lit("rel_e157", 4'b0000, 0, 0, 0);
        goto(158);     lit("rel_e158", 4'b0001, 0, 0, 0);
        goto(170);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
